// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic register chain placed between two CPU pipeline stages. A payload
// enters slot 0, walks slot by slot towards the output and leaves through the
// last slot, or through an optional skid slot behind it. Flow control is
// valid/ready at both ends. A hazard stall freezes the whole chain and a
// branch flush drops every held payload. Both load BUBBLE_VALUE back into
// every slot.
//
// Parameters
//   WIDTH        payload width in bits
//   STAGES       register slots in series (1..8)
//   SKID         1: skid slot present, in_ready independent of out_ready
//                0: no skid slot, in_ready combinational from out_ready
//   BUBBLE_VALUE payload loaded into every slot on flush/reset
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; drops all payloads
//   in_valid   upstream payload valid
//   in_ready   block accepts a payload this cycle
//   in_data    upstream payload
//   stall      hazard hold: nothing moves, no transfer at either end
//   flush      discard all held payloads at the next edge
//   out_valid  downstream payload valid
//   out_ready  downstream accepts
//   out_data   downstream payload
//   occupancy  number of valid slots, skid slot included
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
   parameter int               WIDTH        = 64,
   parameter int               STAGES       = 1,
   parameter int               SKID         = 1,
   parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        stall,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic [$clog2(STAGES+2)-1:0] occupancy
);

   localparam int OCC_W = $clog2(STAGES+2);
   localparam int LAST  = STAGES - 1;

   // Flattened view of the slot registers, gathered from the generate blocks.
   logic [STAGES-1:0] slot_valid;
   logic [WIDTH-1:0]  slot_data [STAGES];

   // slot_move[i]: slot i takes the content of its predecessor this cycle.
   // True when slot i is empty or its own content moves on.
   logic [STAGES-1:0] slot_move;

   // The last slot's content may leave this cycle (to the output or the skid).
   logic              last_drain;
   logic              skid_full;
   logic              clear;
   logic              accept;

   // Reset and flush have identical effect on the datapath.
   assign clear  = reset | flush;

   // A payload offered during reset, flush or stall is never taken.
   assign in_ready = ~reset & ~flush & slot_move[0];
   assign accept   = in_valid & in_ready;

   // A slot can move when any slot at or after it is empty, or the tail
   // drains. Scanning from the tail with an accumulator keeps this a flat
   // function of registered state and out_ready, with no ripple through
   // slot_move itself.
   always_comb begin
      logic space_ahead;
      space_ahead = last_drain;
      slot_move   = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         space_ahead  = space_ahead | ~slot_valid[i];
         slot_move[i] = space_ahead & ~stall;
      end
   end

   // -------------------------------------------------------------------------
   // Register slots
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_slot
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;
         logic             src_valid;
         logic [WIDTH-1:0] src_data;

         if (gi == 0) begin : g_head
            assign src_valid = accept;
            assign src_data  = in_data;
         end else begin : g_body
            assign src_valid = slot_valid[gi-1];
            assign src_data  = slot_data[gi-1];
         end

         // An empty predecessor moves a bubble forward. The data is kept in
         // that case, so out_data only changes when real payloads move.
         always_ff @(posedge clk) begin
            if (clear) begin
               valid_reg <= 1'b0;
               data_reg  <= BUBBLE_VALUE;
            end else if (slot_move[gi]) begin
               valid_reg <= src_valid;
               if (src_valid) begin
                  data_reg <= src_data;
               end
            end
         end

         assign slot_valid[gi] = valid_reg;
         assign slot_data[gi]  = data_reg;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Output side: optional skid slot
   // -------------------------------------------------------------------------
   generate
      if (SKID != 0) begin : g_skid
         logic             skid_valid_reg;
         logic [WIDTH-1:0] skid_data_reg;
         logic             skid_load;
         logic             skid_drain;

         // The tail only looks at the registered skid flag. This removes
         // every path from out_ready to in_ready. When the tail is presented
         // and refused, its payload parks in the skid slot.
         assign last_drain = ~skid_valid_reg;
         assign skid_load  = ~stall & ~skid_valid_reg & slot_valid[LAST] & ~out_ready;
         assign skid_drain = ~stall & skid_valid_reg & out_ready;

         always_ff @(posedge clk) begin
            if (clear) begin
               skid_valid_reg <= 1'b0;
               skid_data_reg  <= BUBBLE_VALUE;
            end else if (skid_load) begin
               skid_valid_reg <= 1'b1;
               skid_data_reg  <= slot_data[LAST];
            end else if (skid_drain) begin
               skid_valid_reg <= 1'b0;
            end
         end

         // The skid slot holds the oldest payload, so it is shown first. With
         // out_ready steady at 1 the skid never fills, so it adds no latency.
         assign skid_full = skid_valid_reg;
         assign out_valid = ~stall & (skid_valid_reg | slot_valid[LAST]);
         assign out_data  = skid_valid_reg ? skid_data_reg : slot_data[LAST];
      end else begin : g_noskid
         // Without a skid slot the tail moves exactly when the consumer takes
         // it. A full chain can still accept if the output frees a slot in
         // the same cycle.
         assign last_drain = out_ready;
         assign skid_full  = 1'b0;
         assign out_valid  = ~stall & slot_valid[LAST];
         assign out_data   = slot_data[LAST];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Occupancy: population count of all valid flags
   // -------------------------------------------------------------------------
   always_comb begin
      occupancy = OCC_W'(skid_full);
      for (int i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(slot_valid[i]);
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Two instances: dut_a (STAGES=3, SKID=1, BUBBLE=0xEE) covers streaming,
// back-pressure, flush, stall and reset. dut_b (STAGES=1, SKID=0) covers the
// combinational ready path. The stimulus pushes accepted payloads into
// per-instance queues. Independent monitors pop and compare on every output
// transfer.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut_a signals
   logic       a_reset, a_in_valid, a_in_ready, a_stall, a_flush;
   logic       a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data;
   logic [2:0] a_occupancy;

   // dut_b signals
   logic       b_reset, b_in_valid, b_in_ready, b_stall, b_flush;
   logic       b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [1:0] b_occupancy;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   pipe_stage_elastic #(
      .WIDTH(8), .STAGES(3), .SKID(1), .BUBBLE_VALUE(8'hEE)
   ) dut_a (
      .clk(clk), .reset(a_reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .stall(a_stall), .flush(a_flush),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .occupancy(a_occupancy)
   );

   pipe_stage_elastic #(
      .WIDTH(8), .STAGES(1), .SKID(0), .BUBBLE_VALUE(8'h00)
   ) dut_b (
      .clk(clk), .reset(b_reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .stall(b_stall), .flush(b_flush),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occupancy)
   );

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Offer one payload to dut_a and hold it until it is accepted (bounded).
   task automatic send_a(input logic [7:0] d);
      int n;
      n = 0;
      a_in_valid = 1'b1;
      a_in_data  = d;
      forever begin
         @(negedge clk);
         if (a_in_ready === 1'b1) begin
            exp_a.push_back(d);
            break;
         end
         n++;
         if (n > 40) begin
            tests++;
            fails++;
            $display("FAIL send_a_timeout data=%h in_ready=%b required=1", d, a_in_ready);
            break;
         end
      end
      next();
      a_in_valid = 1'b0;
   endtask

   // --------------------------------------------------------------- monitors
   always @(negedge clk) begin
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
         tests++;
         if (exp_a.size() == 0) begin
            fails++;
            $display("FAIL a_unexpected_out actual=%h required=none", a_out_data);
         end else begin
            logic [7:0] e;
            e = exp_a.pop_front();
            if (a_out_data !== e) begin
               fails++;
               $display("FAIL a_out_data actual=%h required=%h", a_out_data, e);
            end else begin
               $display("[TB] A out %h ok", a_out_data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
         tests++;
         if (exp_b.size() == 0) begin
            fails++;
            $display("FAIL b_unexpected_out actual=%h required=none", b_out_data);
         end else begin
            logic [7:0] e;
            e = exp_b.pop_front();
            if (b_out_data !== e) begin
               fails++;
               $display("FAIL b_out_data actual=%h required=%h", b_out_data, e);
            end else begin
               $display("[TB] B out %h ok", b_out_data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = 8'h00; a_stall = 1'b0;
      a_flush = 1'b0; a_out_ready = 1'b0;
      b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_stall = 1'b0;
      b_flush = 1'b0; b_out_ready = 1'b0;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      check("rst_a_in_ready",  32'(a_in_ready),  32'(0));
      check("rst_a_out_valid", 32'(a_out_valid), 32'(0));
      check("rst_a_out_data",  32'(a_out_data),  32'h00EE);
      check("rst_a_occupancy", 32'(a_occupancy), 32'(0));
      check("rst_b_in_ready",  32'(b_in_ready),  32'(0));
      check("rst_b_out_data",  32'(b_out_data),  32'h0000);
      next();
      a_reset = 1'b0;
      b_reset = 1'b0;
      @(negedge clk);
      check("post_rst_a_in_ready", 32'(a_in_ready), 32'(1));
      check("post_rst_b_in_ready", 32'(b_in_ready), 32'(1));
      next();

      // 1: stream 0x10..0x1F with out_ready=1
      $display("[TB] test 1 stream");
      a_out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 8'(8'h10 + i);
         @(negedge clk);
         check("t1_in_ready",  32'(a_in_ready),  32'(1));
         check("t1_out_valid", 32'(a_out_valid), 32'(i >= 3));
         check("t1_occupancy", 32'(a_occupancy), 32'((i < 3) ? i : 3));
         exp_a.push_back(a_in_data);
         next();
      end
      a_in_valid = 1'b0;
      for (int i = 16; i < 20; i++) begin
         @(negedge clk);
         check("t1_drain_valid", 32'(a_out_valid), 32'(i < 19));
         next();
      end
      check("t1_all_delivered", 32'(exp_a.size()), 32'(0));

      // 2: out_ready low for 6 cycles in the middle of a stream
      $display("[TB] test 2 backpressure");
      fork
         begin
            for (int i = 0; i < 8; i++) send_a(8'(8'h30 + i));
         end
         begin
            next();
            next();
            a_out_ready = 1'b0;
            repeat (5) next();
            @(negedge clk);
            check("t2_occupancy_full", 32'(a_occupancy), 32'(4));
            check("t2_in_ready_full",  32'(a_in_ready),  32'(0));
            next();
            a_out_ready = 1'b1;
         end
      join
      repeat (10) next();
      check("t2_all_delivered", 32'(exp_a.size()), 32'(0));

      // 3: fill to occupancy 4, then flush while offering 0xAA
      $display("[TB] test 3 flush");
      a_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_a(8'(8'h40 + i));
      @(negedge clk);
      check("t3_occupancy_full", 32'(a_occupancy), 32'(4));
      check("t3_in_ready_full",  32'(a_in_ready),  32'(0));
      next();
      a_flush    = 1'b1;
      a_in_valid = 1'b1;
      a_in_data  = 8'hAA;
      @(negedge clk);
      check("t3_flush_in_ready",  32'(a_in_ready),  32'(0));
      check("t3_flush_out_valid", 32'(a_out_valid), 32'(1));
      check("t3_flush_out_data",  32'(a_out_data),  32'h0040);
      exp_a.delete();
      next();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      @(negedge clk);
      check("t3_post_out_valid", 32'(a_out_valid), 32'(0));
      check("t3_post_occupancy", 32'(a_occupancy), 32'(0));
      check("t3_post_out_data",  32'(a_out_data),  32'h00EE);
      next();
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_stays_empty", 32'(a_out_valid), 32'(0));
         next();
      end

      // 4: stall two cycles with 0x21..0x23 in flight
      $display("[TB] test 4 stall");
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 8'(8'h21 + i);
         @(negedge clk);
         check("t4_in_ready", 32'(a_in_ready), 32'(1));
         exp_a.push_back(a_in_data);
         next();
      end
      a_stall    = 1'b1;
      a_in_valid = 1'b1;
      a_in_data  = 8'h99;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t4_stall_in_ready",  32'(a_in_ready),  32'(0));
         check("t4_stall_out_valid", 32'(a_out_valid), 32'(0));
         check("t4_stall_out_data",  32'(a_out_data),  32'h0021);
         check("t4_stall_occupancy", 32'(a_occupancy), 32'(3));
         next();
      end
      a_stall    = 1'b0;
      a_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t4_release_valid", 32'(a_out_valid), 32'(k < 3));
         if (k < 3) check("t4_release_data", 32'(a_out_data), 32'(8'h21 + k));
         next();
      end

      // 5: reset together with flush mid-stream, then single item 0x55
      $display("[TB] test 5 reset");
      for (int i = 0; i < 2; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 8'(8'h50 + i);
         @(negedge clk);
         exp_a.push_back(a_in_data);
         next();
      end
      a_reset    = 1'b1;
      a_flush    = 1'b1;
      a_in_data  = 8'h5A;
      @(negedge clk);
      check("t5_rst_in_ready", 32'(a_in_ready), 32'(0));
      exp_a.delete();
      next();
      a_reset    = 1'b0;
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      @(negedge clk);
      check("t5_post_occupancy", 32'(a_occupancy), 32'(0));
      check("t5_post_out_valid", 32'(a_out_valid), 32'(0));
      check("t5_post_out_data",  32'(a_out_data),  32'h00EE);
      next();
      a_in_valid = 1'b1;
      a_in_data  = 8'h55;
      @(negedge clk);
      check("t5_accept", 32'(a_in_ready), 32'(1));
      exp_a.push_back(8'h55);
      next();
      a_in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("t5_latency_valid", 32'(a_out_valid), 32'(k == 3));
         if (k == 3) check("t5_latency_data", 32'(a_out_data), 32'h0055);
         next();
      end
      next();
      check("t5_all_delivered", 32'(exp_a.size()), 32'(0));

      // 6: dut_b, out_ready toggling every cycle
      $display("[TB] test 6 no skid");
      begin
         int  cur;
         logic exp_rdy;
         cur = 0;
         b_in_valid = 1'b1;
         for (int j = 0; j < 12; j++) begin
            b_out_ready = (j % 2 == 1);
            b_in_data   = 8'(8'h60 + cur);
            @(negedge clk);
            exp_rdy = (j == 0) || (j % 2 == 1);
            check("t6_in_ready",  32'(b_in_ready),  32'(exp_rdy));
            check("t6_out_valid", 32'(b_out_valid), 32'(j >= 1));
            if (exp_rdy) begin
               exp_b.push_back(b_in_data);
               cur++;
            end
            next();
         end
         b_in_valid  = 1'b0;
         b_out_ready = 1'b1;
         repeat (3) next();
         check("t6_all_delivered", 32'(exp_b.size()), 32'(0));
         check("t6_occupancy_end", 32'(b_occupancy), 32'(0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
